// File: rtl/epoch_key_lock_fsm.sv
// Key-locked present-state register: a correct epoch key lets the external
// FSM advance, a wrong key diverts it to a decoy state and marks tampering.
module epoch_key_lock_fsm #(
   parameter int                           KEY_W       = 16,
   parameter int                           NUM_EPOCH   = 5,
   parameter int                           EPOCH_LEN   = 13,
   parameter int                           STATE_W     = 4,
   parameter int                           RESET_STATE = 1,
   parameter logic [NUM_EPOCH*KEY_W-1:0]   KEYS        = 80'h3B9E_F418_6D02_1E7B_A5C3,
   parameter logic [NUM_EPOCH*STATE_W-1:0] DECOYS      = 20'h26743,
   parameter int                           ERR_W       = 8,
   localparam int                          EPOCH_W     = $clog2(NUM_EPOCH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [KEY_W-1:0]   key,
   input  logic [STATE_W-1:0] nx_state,
   output logic [STATE_W-1:0] pr_state,
   output logic [EPOCH_W-1:0] epoch,
   output logic               key_ok,
   output logic [ERR_W-1:0]   err_cnt,
   output logic               tamper
);

   localparam int                 CYC_W      = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
   localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(EPOCH_LEN - 1);
   localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(NUM_EPOCH - 1);
   localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

   logic [KEY_W-1:0]   key_tab   [NUM_EPOCH];
   logic [STATE_W-1:0] decoy_tab [NUM_EPOCH];

   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic [STATE_W-1:0] pr_state_q, pr_state_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
   logic               tamper_q, tamper_d;

   for (genvar e = 0; e < NUM_EPOCH; e++) begin : g_tab
      assign key_tab[e]   = KEYS[e*KEY_W +: KEY_W];
      assign decoy_tab[e] = DECOYS[e*STATE_W +: STATE_W];
   end

   // Key and decoy lookups use the registered epoch, so the boundary edge
   // is still judged against the epoch that is ending.
   assign key_ok = (key == key_tab[epoch_q]);

   always_comb begin
      cyc_d      = cyc_q;
      epoch_d    = epoch_q;
      pr_state_d = pr_state_q;
      err_cnt_d  = err_cnt_q;
      tamper_d   = tamper_q;
      if (en) begin
         if (cyc_q == CYC_LAST) begin
            cyc_d   = '0;
            epoch_d = (epoch_q == EPOCH_LAST) ? '0 : epoch_q + 1'b1;
         end else begin
            cyc_d = cyc_q + 1'b1;
         end
         if (key_ok) begin
            pr_state_d = nx_state;
         end else begin
            pr_state_d = decoy_tab[epoch_q];
            tamper_d   = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
               err_cnt_d = err_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         cyc_q      <= '0;
         epoch_q    <= '0;
         pr_state_q <= STATE_W'(RESET_STATE);
         err_cnt_q  <= '0;
         tamper_q   <= 1'b0;
      end else begin
         cyc_q      <= cyc_d;
         epoch_q    <= epoch_d;
         pr_state_q <= pr_state_d;
         err_cnt_q  <= err_cnt_d;
         tamper_q   <= tamper_d;
      end
   end

   assign pr_state = pr_state_q;
   assign epoch    = epoch_q;
   assign err_cnt  = err_cnt_q;
   assign tamper   = tamper_q;

endmodule
